// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
//   Pipelined add/subtract unit: s = x + (k ? ~y : y) + ci over WIDTH bits.
//   The carry chain is split into CHUNK-bit slices. Each slice gets one register
//   stage, so latency is WIDTH/CHUNK cycles and throughput is one beat per cycle.
//   The whole pipeline stalls together when the result is not taken.
//
//   Optional feature: define ADDSUB_SAT_EN to saturate s to the signed min/max
//   on overflow. cu, ov and zero always describe the raw sum.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid        in_ready   unit can accept a beat
//   x, y       operands (WIDTH)          ci, k      carry in, invert y
//   out_valid  result beat valid         out_ready  downstream accepts result
//   s          sum/difference (WIDTH)
//   cu         carry out of the MSB
//   ov         signed overflow
//   zero       raw sum == 0
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cu,
    output logic             ov,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             stall;

    // Inputs seen by each stage. Stage 0 reads the ports. Stage i reads the
    // registers of stage i-1.
    logic [WIDTH-1:0] src_x  [STAGES];
    logic [WIDTH-1:0] src_yk [STAGES];
    logic [WIDTH-1:0] src_ps [STAGES];
    logic             src_c  [STAGES];
    logic             src_v  [STAGES];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cu_q, cu_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    assign src_x[0]  = x;
    assign src_yk[0] = k ? ~y : y;
    assign src_ps[0] = '0;
    assign src_c[0]  = ci;
    assign src_v[0]  = in_valid && in_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [CHUNK:0]   add_c;
        logic [WIDTH-1:0] ps_next;

        assign add_c = {1'b0, src_x[i][i*CHUNK +: CHUNK]}
                     + {1'b0, src_yk[i][i*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, src_c[i]};

        always_comb begin
            ps_next = src_ps[i];
            ps_next[i*CHUNK +: CHUNK] = add_c[CHUNK-1:0];
        end

        if (i < STAGES - 1) begin : g_reg
            // The carry crosses into the next slice only through c_q. There is
            // never a combinational path from one stage to the next.
            logic [WIDTH-1:0] x_q, x_d;
            logic [WIDTH-1:0] yk_q, yk_d;
            logic [WIDTH-1:0] ps_q, ps_d;
            logic             c_q, c_d;
            logic             v_q, v_d;

            always_comb begin
                x_d  = x_q;
                yk_d = yk_q;
                ps_d = ps_q;
                c_d  = c_q;
                v_d  = v_q;
                if (!stall) begin
                    v_d = src_v[i];
                    if (src_v[i]) begin
                        x_d  = src_x[i];
                        yk_d = src_yk[i];
                        ps_d = ps_next;
                        c_d  = add_c[CHUNK];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q  <= '0;
                    yk_q <= '0;
                    ps_q <= '0;
                    c_q  <= 1'b0;
                    v_q  <= 1'b0;
                end else begin
                    x_q  <= x_d;
                    yk_q <= yk_d;
                    ps_q <= ps_d;
                    c_q  <= c_d;
                    v_q  <= v_d;
                end
            end

            assign src_x[i+1]  = x_q;
            assign src_yk[i+1] = yk_q;
            assign src_ps[i+1] = ps_q;
            assign src_c[i+1]  = c_q;
            assign src_v[i+1]  = v_q;
        end else begin : g_out
            logic             raw_ov;
            logic [WIDTH-1:0] s_res;

            assign raw_ov = (src_x[i][WIDTH-1] == src_yk[i][WIDTH-1])
                         && (ps_next[WIDTH-1] != src_x[i][WIDTH-1]);

`ifdef ADDSUB_SAT_EN
            // Overflow means the true sum has the same sign as x.
            // Clamp toward that sign.
            assign s_res = !raw_ov           ? ps_next :
                           src_x[i][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                               {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign s_res = ps_next;
`endif

            // Result registers change only when a valid beat lands. While
            // out_valid is low they still hold the last result.
            always_comb begin
                out_valid_d = out_valid_q;
                s_d         = s_q;
                cu_d        = cu_q;
                ov_d        = ov_q;
                zero_d      = zero_q;
                if (!stall) begin
                    out_valid_d = src_v[i];
                    if (src_v[i]) begin
                        s_d    = s_res;
                        cu_d   = add_c[CHUNK];
                        ov_d   = raw_ov;
                        zero_d = (ps_next == '0);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    s_q         <= '0;
                    cu_q        <= 1'b0;
                    ov_q        <= 1'b0;
                    zero_q      <= 1'b0;
                end else begin
                    out_valid_q <= out_valid_d;
                    s_q         <= s_d;
                    cu_q        <= cu_d;
                    ov_q        <= ov_d;
                    zero_q      <= zero_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cu        = cu_q;
    assign ov        = ov_q;
    assign zero      = zero_q;

endmodule
